// File: rtl/mac_dot_sched.sv
// Dot-product job sequencer for a single MAC instance: clears the MAC, streams operand pairs
// from two 1-cycle-latency read ports, counts MAC strobes and returns the final sum.
module mac_dot_sched #(
    parameter int unsigned INPUT_WIDTH  = 16,
    parameter int unsigned OUTPUT_WIDTH = 40,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned LEN_W        = 10,
    parameter int unsigned CLR_CYCLES   = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start_valid,
    output logic                    o_start_ready,
    input  logic [LEN_W-1:0]        i_len,
    input  logic [ADDR_W-1:0]       i_base_a,
    input  logic [ADDR_W-1:0]       i_base_b,
    output logic                    o_rd_en,
    output logic [ADDR_W-1:0]       o_rd_addr_a,
    output logic [ADDR_W-1:0]       o_rd_addr_b,
    input  logic [INPUT_WIDTH-1:0]  i_rd_data_a,
    input  logic [INPUT_WIDTH-1:0]  i_rd_data_b,
    output logic                    o_mac_rst,
    output logic [INPUT_WIDTH-1:0]  o_mac_a,
    output logic [INPUT_WIDTH-1:0]  o_mac_b,
    output logic                    o_mac_valid,
    input  logic [OUTPUT_WIDTH-1:0] i_mac_val,
    input  logic                    i_mac_valid,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic [OUTPUT_WIDTH-1:0] o_res_data,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CLR_W-1:0]  CLR_ONE  = CLR_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [2:0]              state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [ADDR_W-1:0]       addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]       addr_b_q, addr_b_d;
    logic [CLR_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [LEN_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]        res_cnt_q, res_cnt_d;
    logic                    got_all_q, got_all_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [OUTPUT_WIDTH-1:0] res_data_q, res_data_d;
    logic                    err_q, err_d;
    logic                    mac_valid_q;
    logic                    mac_rst_q;
    logic [LEN_W-1:0]        len_m1;

    assign len_m1 = len_q - LEN_ONE;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        clr_cnt_d   = clr_cnt_q;
        issue_cnt_d = issue_cnt_q;
        res_cnt_d   = res_cnt_q;
        got_all_d   = got_all_q;
        to_cnt_d    = to_cnt_q;
        res_data_d  = res_data_q;
        err_d       = err_q;

        // Strobes count from ISSUE entry; anything past the len-th is ignored.
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && i_mac_valid && !got_all_q) begin
            res_cnt_d = res_cnt_q + LEN_ONE;
            if (res_cnt_q == len_m1) begin
                got_all_d  = 1'b1;
                res_data_d = i_mac_val;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_start_valid) begin
                    len_d       = i_len;
                    addr_a_d    = i_base_a;
                    addr_b_d    = i_base_b;
                    err_d       = 1'b0;
                    clr_cnt_d   = '0;
                    issue_cnt_d = '0;
                    res_cnt_d   = '0;
                    got_all_d   = 1'b0;
                    to_cnt_d    = '0;
                    if (i_len == '0) begin
                        res_data_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + CLR_ONE;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                addr_a_d    = addr_a_q + ADDR_ONE;
                addr_b_d    = addr_b_q + ADDR_ONE;
                issue_cnt_d = issue_cnt_q + LEN_ONE;
                if (issue_cnt_q == len_m1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (got_all_d) begin
                    state_d = S_DONE;
                end else if (i_mac_valid) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    res_data_d = i_mac_val;
                    state_d    = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            S_DONE: begin
                if (i_res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            clr_cnt_q   <= '0;
            issue_cnt_q <= '0;
            res_cnt_q   <= '0;
            got_all_q   <= 1'b0;
            to_cnt_q    <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            clr_cnt_q   <= clr_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            res_cnt_q   <= res_cnt_d;
            got_all_q   <= got_all_d;
            to_cnt_q    <= to_cnt_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            mac_valid_q <= o_rd_en;
            // Registered from next state so the clear pulse lines up with the CLEAR cycles.
            mac_rst_q   <= (state_d == S_CLEAR);
        end
    end

    assign o_start_ready = (state_q == S_IDLE);
    assign o_busy        = (state_q != S_IDLE);
    assign o_rd_en       = (state_q == S_ISSUE);
    assign o_rd_addr_a   = addr_a_q;
    assign o_rd_addr_b   = addr_b_q;
    assign o_mac_rst     = mac_rst_q;
    assign o_mac_a       = i_rd_data_a;
    assign o_mac_b       = i_rd_data_b;
    assign o_mac_valid   = mac_valid_q;
    assign o_res_valid   = (state_q == S_DONE);
    assign o_res_data    = res_data_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_mac_dot_sched.sv
// Scoreboard bench for mac_dot_sched: operand memories and a pipelined MAC stand-in surround the
// DUT; a monitor process pops expected job results and checks protocol and timing every cycle.
module tb_mac_dot_sched;

    localparam int IW  = 16;
    localparam int OW  = 40;
    localparam int AW  = 10;
    localparam int LW  = 10;
    localparam int CLR = 4;
    localparam int TO  = 64;
    localparam int LAT = 3;  // MAC stand-in: strobe comes LAT+1 cycles after o_mac_valid

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_valid;
    logic          start_ready;
    logic [LW-1:0] len;
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [IW-1:0] rd_data_a;
    logic [IW-1:0] rd_data_b;
    logic          mac_rst;
    logic [IW-1:0] mac_a;
    logic [IW-1:0] mac_b;
    logic          mac_valid;
    logic [OW-1:0] mac_val;
    logic          mac_strobe;
    logic          res_valid;
    logic          res_ready;
    logic [OW-1:0] res_data;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    mac_dot_sched #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .ADDR_W      (AW),
        .LEN_W       (LW),
        .CLR_CYCLES  (CLR),
        .TIMEOUT     (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_valid(start_valid),
        .o_start_ready(start_ready),
        .i_len        (len),
        .i_base_a     (base_a),
        .i_base_b     (base_b),
        .o_rd_en      (rd_en),
        .o_rd_addr_a  (rd_addr_a),
        .o_rd_addr_b  (rd_addr_b),
        .i_rd_data_a  (rd_data_a),
        .i_rd_data_b  (rd_data_b),
        .o_mac_rst    (mac_rst),
        .o_mac_a      (mac_a),
        .o_mac_b      (mac_b),
        .o_mac_valid  (mac_valid),
        .i_mac_val    (mac_val),
        .i_mac_valid  (mac_strobe),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_data   (res_data),
        .o_busy       (busy),
        .o_err        (err)
    );

    // ---------------- environment: memories and MAC stand-in ----------------
    logic [IW-1:0] mem_a [1024];
    logic [IW-1:0] mem_b [1024];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end
    end

    logic          pv [LAT];
    logic [OW-1:0] pp [LAT];
    logic [OW-1:0] acc;
    logic          mv;
    int            scnt;
    bit            drop_en;
    int            drop_len;
    bit            hold_ready;

    assign mac_val    = acc;
    assign mac_strobe = mv;

    always @(posedge clk) begin
        if (mac_rst) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
            acc  <= '0;
            mv   <= 1'b0;
            scnt <= 0;
        end else begin
            pv[0] <= mac_valid;
            pp[0] <= OW'(mac_a) * OW'(mac_b);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
            end
            if (pv[LAT-1]) begin
                acc  <= acc + pp[LAT-1];
                scnt <= scnt + 1;
                mv   <= !(drop_en && (scnt + 1 == drop_len));
            end else begin
                mv <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [OW-1:0] data;
        logic          err;
        int            len;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [OW-1:0] model(input int n, input int ba, input int bb);
        logic [OW-1:0] s;
        s = '0;
        for (int k = 0; k < n; k++) begin
            s = s + OW'(mem_a[(ba + k) % 1024]) * OW'(mem_b[(bb + k) % 1024]);
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            start_cyc, first_valid_cyc, last_strobe_cyc, wd;
    int            rd_idx, rst_cnt;
    logic [AW-1:0] job_ba, job_bb, prev_addr_a, prev_addr_b;
    logic          prev_rd_en, prev_valid, prev_ready;
    logic [OW-1:0] prev_data;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            chk("rst_rd_en", 64'(rd_en), 64'd0);
            chk("rst_mac_rst", 64'(mac_rst), 64'd1);
            chk("rst_mac_valid", 64'(mac_valid), 64'd0);
            chk("rst_res_valid", 64'(res_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_start_ready", 64'(start_ready), 64'd1);
            chk("rst_err", 64'(err), 64'd0);
            prev_rd_en = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            wd         = 0;
        end else begin
            cyc++;
            if (mac_strobe) last_strobe_cyc = cyc;
            chk("mac_valid_trails_rd_en", 64'(mac_valid), 64'(prev_rd_en));
            if (prev_rd_en) begin
                chk("mac_a_data", 64'(mac_a), 64'(mem_a[prev_addr_a]));
                chk("mac_b_data", 64'(mac_b), 64'(mem_b[prev_addr_b]));
            end
            chk("busy_vs_ready", 64'(busy), 64'(!start_ready));
            if (res_valid) chk("start_ready_in_done", 64'(start_ready), 64'd0);
            if (prev_valid && !prev_ready) begin
                chk("res_valid_held", 64'(res_valid), 64'd1);
                chk("res_data_stable", 64'(res_data), 64'(prev_data));
            end
            if (res_valid && !prev_valid) first_valid_cyc = cyc;
            if (mac_rst) rst_cnt++;
            if (rd_en) begin
                chk("rd_addr_a", 64'(rd_addr_a), 64'(AW'(job_ba + AW'(rd_idx))));
                chk("rd_addr_b", 64'(rd_addr_b), 64'(AW'(job_bb + AW'(rd_idx))));
                rd_idx++;
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(res_valid), 64'd0);
                end else begin
                    exp_t e;
                    int   lat;
                    e   = sb.pop_front();
                    lat = first_valid_cyc - start_cyc;
                    chk("res_data", 64'(res_data), 64'(e.data));
                    chk("res_err", 64'(err), 64'(e.err));
                    chk("rd_en_pulses", 64'(rd_idx), 64'(e.len));
                    chk("mac_rst_cycles", 64'(rst_cnt), 64'((e.len == 0) ? 0 : CLR));
                    if (e.err) chk("timeout_gap", 64'(first_valid_cyc - last_strobe_cyc),
                                   64'(TO + 1));
                    else if (e.len == 0) chk("len0_latency", 64'(lat >= 1 && lat <= 2), 64'd1);
                    else chk("job_latency", 64'(lat), 64'(e.len + CLR + 2 + LAT + 1));
                end
                wd = 0;
            end
            if (start_valid && start_ready) begin
                start_cyc = cyc;
                job_ba    = base_a;
                job_bb    = base_b;
                rd_idx    = 0;
                rst_cnt   = 0;
            end
            if (sb.size() != 0) begin
                wd++;
                if (wd > 4000) begin
                    chk("result_timeout", 64'(res_valid), 64'd1);
                    void'(sb.pop_front());
                    wd = 0;
                end
            end
            prev_rd_en  = rd_en;
            prev_addr_a = rd_addr_a;
            prev_addr_b = rd_addr_b;
            prev_valid  = res_valid;
            prev_ready  = res_ready;
            prev_data   = res_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int n = 0;
        while (!start_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 6000) begin
                $display("FAIL start_ready_timeout: got 0, expected 1");
                $fatal(1);
            end
        end
    endtask

    task automatic issue(input int n, input int ba, input int bb);
        @(posedge clk);
        #1;
        wait_ready();
        start_valid = 1'b1;
        len         = LW'(n);
        base_a      = AW'(ba);
        base_b      = AW'(bb);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 6000) begin
                $display("FAIL wait_done_timeout: got %0d pending, expected 0", sb.size());
                $fatal(1);
            end
        end
    endtask

    task automatic run_job(input int n, input int ba, input int bb, input logic [OW-1:0] expd,
                           input bit drop);
        exp_t e;
        e.data   = expd;
        e.err    = drop;
        e.len    = n;
        sb.push_back(e);
        drop_en  = drop;
        drop_len = n;
        issue(n, ba, bb);
        wait_done();
    endtask

    initial begin
        start_valid = 1'b0;
        len         = '0;
        base_a      = '0;
        base_b      = '0;
        hold_ready  = 1'b0;
        drop_en     = 1'b0;
        drop_len    = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = IW'($urandom);
            mem_b[i] = IW'($urandom);
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed: simple dot product
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = IW'(i + 1);
            mem_b[i] = IW'(i + 5);
        end
        run_job(4, 0, 0, 40'd70, 1'b0);

        // Directed: empty job
        run_job(0, 17, 33, 40'd0, 1'b0);

        // Directed: consecutive jobs, accumulator must be cleared between them
        mem_a[100] = 16'd3; mem_a[101] = 16'd3; mem_b[200] = 16'd3; mem_b[201] = 16'd3;
        mem_a[300] = 16'd2; mem_b[400] = 16'd5;
        run_job(2, 100, 200, 40'd18, 1'b0);
        run_job(1, 300, 400, 40'd10, 1'b0);

        // Directed: address wrap and full-width products
        mem_a[1023] = 16'hFFFF; mem_a[0] = 16'hFFFF; mem_a[1] = 16'hFFFF;
        mem_b[500]  = 16'hFFFF; mem_b[501] = 16'hFFFF; mem_b[502] = 16'hFFFF;
        run_job(3, 1023, 500, 40'h2FFFA0003, 1'b0);

        // Directed: consumer stalls in DONE while a second start is offered
        begin
            exp_t e;
            int   n = 0;
            hold_ready = 1'b1;
            e.data = model(3, 10, 20);
            e.err  = 1'b0;
            e.len  = 3;
            sb.push_back(e);
            drop_en = 1'b0;
            issue(3, 10, 20);
            while (!res_valid && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            start_valid = 1'b1;
            len         = LW'(5);
            repeat (10) @(posedge clk);
            #1;
            start_valid = 1'b0;
            hold_ready  = 1'b0;
            wait_done();
        end

        // Randomized jobs, including a wrapping maximum-length one
        for (int j = 0; j < 10; j++) begin
            int n, ba, bb;
            n  = int'($urandom_range(1, 40));
            ba = int'($urandom_range(0, 1023));
            bb = int'($urandom_range(0, 1023));
            run_job(n, ba, bb, model(n, ba, bb), 1'b0);
        end
        run_job(1023, 700, 5, model(1023, 700, 5), 1'b0);

        // MAC loses its last strobe: drain timeout, then error clears on next job
        run_job(5, 40, 60, model(5, 40, 60), 1'b1);
        run_job(6, 80, 90, model(6, 80, 90), 1'b0);

        // Reset in the middle of ISSUE abandons the job
        begin
            int n = 0;
            drop_en = 1'b0;
            issue(20, 3, 7);
            while (!rd_en && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            #3 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (60) @(posedge clk);
        end
        run_job(7, 123, 456, model(7, 123, 456), 1'b0);

        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
